kernel_launcher: RTL

Host-side launch sequencer directly upstream of the gpu top level. It accepts one kernel launch request at a time and resets the gpu. It then programs the device control register with the thread count, raises and holds gpu start until gpu done, and returns a completion record. The record carries the run cycle count and a timeout flag. All gpu control inputs (reset, device control write, start) are driven exclusively by this block.

---
 rtl/kernel_launcher.sv | 136 +++++++++++++
 1 files changed

// File: rtl/kernel_launcher.sv
// rtl/kernel_launcher.sv - one-at-a-time gpu kernel launch sequencer with completion record
//
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   launch_valid/ready, launch_thread_count   launch request handshake and thread count
//   gpu_reset                        gpu reset, held GPU_RESET_CYCLES per launch
//   gpu_device_control_write_enable, gpu_device_control_data   one-cycle DCR write
//   gpu_start, gpu_done              run level and completion from the gpu
//   result_valid/ready, result_cycles, result_timeout   completion record handshake
//   busy                             high whenever not idle
module kernel_launcher #(
  parameter int CYCLE_COUNT_BITS = 32,
  parameter int GPU_RESET_CYCLES = 2,
  parameter int TIMEOUT_CYCLES   = 100000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        launch_valid,
  output logic                        launch_ready,
  input  logic [7:0]                  launch_thread_count,
  output logic                        gpu_reset,
  output logic                        gpu_device_control_write_enable,
  output logic [7:0]                  gpu_device_control_data,
  output logic                        gpu_start,
  input  logic                        gpu_done,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [CYCLE_COUNT_BITS-1:0] result_cycles,
  output logic                        result_timeout,
  output logic                        busy
);

  localparam int RST_W = (GPU_RESET_CYCLES > 1) ? $clog2(GPU_RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(GPU_RESET_CYCLES - 1);
  localparam logic [CYCLE_COUNT_BITS-1:0] TIMEOUT_VAL = CYCLE_COUNT_BITS'(TIMEOUT_CYCLES);
  localparam logic [CYCLE_COUNT_BITS-1:0] CNT_MAX = {CYCLE_COUNT_BITS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_GPU_RESET,
    S_WRITE_DCR,
    S_RUN,
    S_REPORT
  } state_t;

  state_t                        state, state_next;
  logic [7:0]                    thread_count;
  logic [CYCLE_COUNT_BITS-1:0]   cycle_cnt, cycle_cnt_next;
  logic [RST_W-1:0]              rst_cnt, rst_cnt_next;
  logic [CYCLE_COUNT_BITS-1:0]   res_cycles_next;
  logic                          res_timeout_next;

  always_comb begin
    state_next       = state;
    cycle_cnt_next   = cycle_cnt;
    rst_cnt_next     = rst_cnt;
    res_cycles_next  = result_cycles;
    res_timeout_next = result_timeout;
    case (state)
      S_IDLE: begin
        if (launch_valid) begin
          rst_cnt_next = '0;
          if (launch_thread_count == 8'd0) begin
            // Empty kernel: report immediately, gpu is never touched.
            state_next       = S_REPORT;
            res_cycles_next  = '0;
            res_timeout_next = 1'b0;
          end else begin
            state_next = S_GPU_RESET;
          end
        end
      end
      S_GPU_RESET: begin
        if (rst_cnt == RST_LAST) state_next = S_WRITE_DCR;
        else                     rst_cnt_next = rst_cnt + 1'b1;
      end
      S_WRITE_DCR: begin
        cycle_cnt_next = '0;
        state_next     = S_RUN;
      end
      S_RUN: begin
        // Done takes priority over a simultaneous timeout.
        if (gpu_done) begin
          state_next       = S_REPORT;
          res_cycles_next  = cycle_cnt;
          res_timeout_next = 1'b0;
        end else if ((TIMEOUT_CYCLES != 0) && (cycle_cnt == TIMEOUT_VAL)) begin
          state_next       = S_REPORT;
          res_cycles_next  = TIMEOUT_VAL;
          res_timeout_next = 1'b1;
        end else if (cycle_cnt != CNT_MAX) begin
          cycle_cnt_next = cycle_cnt + 1'b1;
        end
      end
      S_REPORT: begin
        if (result_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up
  // exactly with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                           <= S_IDLE;
      thread_count                    <= 8'd0;
      cycle_cnt                       <= '0;
      rst_cnt                         <= '0;
      launch_ready                    <= 1'b1;
      busy                            <= 1'b0;
      gpu_reset                       <= 1'b0;
      gpu_device_control_write_enable <= 1'b0;
      gpu_device_control_data         <= 8'd0;
      gpu_start                       <= 1'b0;
      result_valid                    <= 1'b0;
      result_cycles                   <= '0;
      result_timeout                  <= 1'b0;
    end else begin
      state          <= state_next;
      cycle_cnt      <= cycle_cnt_next;
      rst_cnt        <= rst_cnt_next;
      result_cycles  <= res_cycles_next;
      result_timeout <= res_timeout_next;
      if (state == S_IDLE && launch_valid) thread_count <= launch_thread_count;
      launch_ready                    <= (state_next == S_IDLE);
      busy                            <= (state_next != S_IDLE);
      gpu_reset                       <= (state_next == S_GPU_RESET);
      gpu_device_control_write_enable <= (state_next == S_WRITE_DCR);
      gpu_device_control_data         <= (state_next == S_WRITE_DCR) ? thread_count : 8'd0;
      gpu_start                       <= (state_next == S_RUN);
      result_valid                    <= (state_next == S_REPORT);
    end
  end

endmodule
